// File: rtl/pcre_engine_pkg.sv
// Shared types, default widths and the class-index helper for the PCRE chain engine.
package pcre_engine_pkg;

    typedef enum logic [0:0] {
        SCAN   = 1'b0,
        REPORT = 1'b1
    } fsm_state_e;

    localparam int unsigned DEF_N_STATES  = 31;
    localparam int unsigned DEF_N_CLASSES = 128;
    localparam int unsigned DEF_CLS_W     = 7;
    localparam int unsigned DEF_OFF_W     = 16;
    localparam int unsigned DEF_CNT_W     = 8;

    // Upper bounds used to size the helper argument so one function serves every instance.
    localparam int unsigned MAX_STATES  = 64;
    localparam int unsigned MAX_CLS_W   = 16;
    localparam int unsigned CLASS_VEC_W = MAX_STATES * MAX_CLS_W;

    // Extract the class index of chain element k from the packed STATE_CLASS vector.
    function automatic int unsigned class_idx(
        input logic [CLASS_VEC_W-1:0] vec,
        input int unsigned            k,
        input int unsigned            cls_w
    );
        logic [CLASS_VEC_W-1:0] sh;
        int unsigned            idx;
        sh  = vec >> (k * cls_w);
        idx = 32'd0;
        for (int unsigned b = 0; b < MAX_CLS_W; b++) begin
            if (b < cls_w) begin
                idx[b] = sh[b];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pcre_chain_elem.sv
// One NFA chain element: a literal/char-class position, optionally a `*` element.
module pcre_chain_elem (
    input  logic clk,
    input  logic sod_n,
    input  logic step,
    input  logic clr,
    input  logic hit,
    input  logic enter,
    input  logic loop,
    output logic a,
    output logic e_next
);

    logic a_r;
    logic a_nxt_s;

    // Next activity: active when this byte hits and the element was entered or is self-looping.
    always_comb begin
        a_nxt_s = a_r;
        if (clr) begin
            a_nxt_s = 1'b0;
        end else if (step) begin
            a_nxt_s = hit & (enter | (loop & a_r));
        end else begin
            a_nxt_s = a_r;
        end
    end

    // Element activity register, cleared by start-of-data.
    always_ff @(posedge clk) begin
        if (!sod_n) begin
            a_r <= 1'b0;
        end else begin
            a_r <= a_nxt_s;
        end
    end

    assign a      = a_r;
    // A `*` element is skippable, so its own entry passes straight through to the successor.
    assign e_next = a_r | (loop & enter);

endmodule

// File: rtl/pcre_chain_engine.sv
// Parametrised NFA chain for one PCRE with sticky match flag and per-packet report handshake.
module pcre_chain_engine
    import pcre_engine_pkg::*;
#(
    parameter int unsigned                 N_STATES    = DEF_N_STATES,
    parameter int unsigned                 N_CLASSES   = DEF_N_CLASSES,
    parameter int unsigned                 CLS_W       = DEF_CLS_W,
    parameter logic [N_STATES*CLS_W-1:0]   STATE_CLASS = {(N_STATES*CLS_W){1'b0}},
    parameter logic [N_STATES-1:0]         STATE_LOOP  = {N_STATES{1'b0}},
    parameter bit                          ANCHORED    = 1'b0,
    parameter int unsigned                 OFF_W       = DEF_OFF_W,
    parameter int unsigned                 CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 sod_n,
    input  logic                 en,
    input  logic                 eod,
    input  logic [N_CLASSES-1:0] char_class,
    output logic                 out,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic                 rpt_match,
    output logic [OFF_W-1:0]     rpt_offset,
    output logic [CNT_W-1:0]     rpt_count
);

    localparam logic [OFF_W-1:0] OFF_MAX = {OFF_W{1'b1}};
    localparam logic [OFF_W-1:0] OFF_ONE = OFF_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    fsm_state_e       state_r, state_nxt_s;
    logic [OFF_W-1:0] byte_cnt_r, offset_r, rpt_offset_r, offset_nxt_s;
    logic [CNT_W-1:0] count_r, rpt_count_r, count_nxt_s;
    logic             out_r, first_r, rpt_valid_r, rpt_match_r;
    logic             first_nxt_s, out_nxt_s, match_nxt_s;
    logic             step_s, clr_s, eod_evt_s, e0_s, e0_la_s;
    logic             acc_s, acc_la_s, acc_evt_s, la_evt_s;

    assign step_s    = (state_r == SCAN) & en;
    assign eod_evt_s = step_s & eod;
    assign clr_s     = (state_r == REPORT) & rpt_ready;
    assign e0_s      = ANCHORED ? (byte_cnt_r == {OFF_W{1'b0}}) : 1'b1;
    // The byte counter never wraps, so an anchored head can never be re-entered on the next byte.
    assign e0_la_s   = ANCHORED ? 1'b0 : 1'b1;

    for (genvar k = 0; k < N_STATES; k++) begin : g_elem
        localparam logic [CLS_W-1:0] CIDX = CLS_W'(class_idx(CLASS_VEC_W'(STATE_CLASS), k, CLS_W));
        localparam logic             LOOP = STATE_LOOP[k];

        logic hit_s, enter_s, enter_la_s, a_s, e_out_s, a_la_s, e_out_la_s;

        assign hit_s = char_class[CIDX];

        if (k == 0) begin : g_head
            assign enter_s    = e0_s;
            assign enter_la_s = e0_la_s;
        end else begin : g_link
            assign enter_s    = g_elem[k-1].e_out_s;
            assign enter_la_s = g_elem[k-1].e_out_la_s;
        end

        pcre_chain_elem u_elem (
            .clk    (clk),
            .sod_n  (sod_n),
            .step   (step_s),
            .clr    (clr_s),
            .hit    (hit_s),
            .enter  (enter_s),
            .loop   (LOOP),
            .a      (a_s),
            .e_next (e_out_s)
        );

        // Lookahead chain on the next-state activity, used only to account a match ending on eod.
        assign a_la_s     = hit_s & (enter_s | (LOOP & a_s));
        assign e_out_la_s = a_la_s | (LOOP & enter_la_s);
    end

    assign acc_s     = g_elem[N_STATES-1].e_out_s;
    assign acc_la_s  = g_elem[N_STATES-1].e_out_la_s;
    assign acc_evt_s = step_s & acc_s;
    assign la_evt_s  = eod_evt_s & acc_la_s;

    // Match accounting: saturating count, first-match offset, sticky flag and report match bit.
    always_comb begin
        count_nxt_s  = count_r;
        offset_nxt_s = offset_r;
        first_nxt_s  = first_r;
        if (acc_evt_s && (count_nxt_s != CNT_MAX)) begin
            count_nxt_s = count_nxt_s + CNT_ONE;
        end else begin
            count_nxt_s = count_nxt_s;
        end
        if (la_evt_s && (count_nxt_s != CNT_MAX)) begin
            count_nxt_s = count_nxt_s + CNT_ONE;
        end else begin
            count_nxt_s = count_nxt_s;
        end
        if (acc_evt_s && !first_r) begin
            first_nxt_s  = 1'b1;
            offset_nxt_s = byte_cnt_r - OFF_ONE;
        end else if (la_evt_s && !first_r) begin
            first_nxt_s  = 1'b1;
            offset_nxt_s = byte_cnt_r;
        end else begin
            first_nxt_s  = first_r;
            offset_nxt_s = offset_r;
        end
        out_nxt_s   = out_r | acc_evt_s;
        match_nxt_s = out_nxt_s | la_evt_s;
    end

    // FSM next state: scan until the last byte, then hold the report until it is taken.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SCAN: begin
                if (eod_evt_s) state_nxt_s = REPORT;
                else           state_nxt_s = SCAN;
            end
            REPORT: begin
                if (rpt_ready) state_nxt_s = SCAN;
                else           state_nxt_s = REPORT;
            end
            default: state_nxt_s = SCAN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!sod_n) begin
            state_r <= SCAN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Byte counter, accounting registers and report registers.
    always_ff @(posedge clk) begin
        if (!sod_n) begin
            byte_cnt_r   <= {OFF_W{1'b0}};
            offset_r     <= {OFF_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            first_r      <= 1'b0;
            out_r        <= 1'b0;
            rpt_valid_r  <= 1'b0;
            rpt_match_r  <= 1'b0;
            rpt_offset_r <= {OFF_W{1'b0}};
            rpt_count_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                SCAN: begin
                    if (step_s) begin
                        byte_cnt_r <= (byte_cnt_r == OFF_MAX) ? byte_cnt_r : byte_cnt_r + OFF_ONE;
                        offset_r   <= offset_nxt_s;
                        count_r    <= count_nxt_s;
                        first_r    <= first_nxt_s;
                        out_r      <= out_nxt_s;
                    end
                    if (eod_evt_s) begin
                        rpt_valid_r  <= 1'b1;
                        rpt_match_r  <= match_nxt_s;
                        rpt_offset_r <= offset_nxt_s;
                        rpt_count_r  <= count_nxt_s;
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        byte_cnt_r  <= {OFF_W{1'b0}};
                        offset_r    <= {OFF_W{1'b0}};
                        count_r     <= {CNT_W{1'b0}};
                        first_r     <= 1'b0;
                        out_r       <= 1'b0;
                        rpt_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rpt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out        = out_r;
    assign rpt_valid  = rpt_valid_r;
    assign rpt_match  = rpt_match_r;
    assign rpt_offset = rpt_offset_r;
    assign rpt_count  = rpt_count_r;

endmodule
